tick_arbiter: RTL

Round-robin arbiter sharing a pair of 8-bit state registers (reg_a, reg_b) among N_REQ requesters, each of which would otherwise own a private tick writing one of them. At most one write is accepted per clock, with an optional locked burst for a single requester, a synchronous clear, and a combinational sum readout. It sits between the per-function tick logic and the shared register pair, so that many ticks can target the same state without multi-driver conflicts.

---
 rtl/tick_arbiter_pkg.sv | 22 ++
 rtl/tick_arbiter_rr_pick.sv | 29 ++
 rtl/tick_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tick_arbiter_pkg.sv
// Shared defaults, FSM state encoding and width helpers for the tick arbiter.
package tick_arbiter_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int WIDTH_DEF     = 8;
    localparam int BURST_MAX_DEF = 4;

    // BURST_MAX is limited to 15, so a 4-bit burst counter always suffices.
    localparam int BURST_W = 4;

    localparam int PTR_W_DEF = $clog2(N_REQ_DEF);

    typedef enum logic [0:0] {
        ROTATE = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_arbiter_rr_pick.sv
// Rotating-priority picker: grants the first set request at or above ptr_i, wrapping at N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [PW-1:0]    idx_o
);

    always_comb begin
        int  j;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/tick_arbiter.sv
// Round-robin arbiter that serialises many tick writers onto one shared register pair,
// with an optional capped burst lock for the current grant holder.
module tick_arbiter
    import tick_arbiter_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ-1:0]       sel,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    input  logic                   clear,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       reg_a,
    output logic [WIDTH-1:0]       reg_b,
    output logic [WIDTH-1:0]       sum,
    output logic                   locked
);

    localparam int PW = ptr_width(N_REQ);
    // With BURST_MAX == 1 the locking transfer already exhausts the burst.
    localparam logic CAN_LOCK = (BURST_MAX > 1);

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [WIDTH-1:0]     reg_a_q, reg_a_d;
    logic [WIDTH-1:0]     reg_b_q, reg_b_d;

    logic [N_REQ-1:0]     pick_grant;
    logic [PW-1:0]        pick_idx;
    logic [N_REQ-1:0]     ack_raw;
    logic [PW-1:0]        grant_idx;
    logic [PW-1:0]        grant_inc;
    logic [PW-1:0]        owner_inc;
    logic [BURST_W-1:0]   burst_inc;
    logic                 xfer;
    logic [WIDTH-1:0]     grant_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    always_comb begin
        ack_raw   = '0;
        grant_idx = pick_idx;
        if (state_q == ROTATE) begin
            ack_raw = pick_grant;
        end else begin
            grant_idx        = owner_q;
            ack_raw[owner_q] = req[owner_q];
        end
    end

    // Grant is suppressed while reset is held and on clear cycles, so no transfer can happen then.
    assign ack        = (rst_n && !clear) ? ack_raw : '0;
    assign xfer       = |ack;
    assign grant_inc  = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign owner_inc  = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign burst_inc  = burst_q + 1'b1;
    assign grant_data = wdata[int'(grant_idx)*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        unique case (state_q)
            ROTATE: begin
                if (xfer) begin
                    if (CAN_LOCK && lock[grant_idx]) begin
                        state_d = LOCKED;
                        owner_d = grant_idx;
                        burst_d = BURST_W'(1);
                    end else begin
                        ptr_d = grant_inc;
                    end
                end
            end
            LOCKED: begin
                if (!clear) begin
                    // The transfer that brings the count to BURST_MAX is the last one of the burst.
                    if (xfer && lock[owner_q] && (burst_inc < BURST_W'(BURST_MAX))) begin
                        burst_d = burst_inc;
                    end else begin
                        state_d = ROTATE;
                        ptr_d   = owner_inc;
                        burst_d = '0;
                    end
                end
            end
            default: state_d = ROTATE;
        endcase
    end

    always_comb begin
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        if (clear) begin
            reg_a_d = '0;
            reg_b_d = '0;
        end else if (xfer) begin
            if (sel[grant_idx]) reg_b_d = grant_data;
            else                reg_a_d = grant_data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ROTATE;
            ptr_q   <= '0;
            owner_q <= '0;
            burst_q <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
        end
    end

    assign reg_a  = reg_a_q;
    assign reg_b  = reg_b_q;
    assign sum    = reg_a_q + reg_b_q;
    assign locked = (state_q == LOCKED);

endmodule
